// File: rtl/aq_cjpeg_pkg.sv
// Shared constants for the JPEG encoder bit packer: marker bytes, FSM encoding
// and default widths.
package aq_cjpeg_pkg;

  localparam int unsigned ACC_W_DEF   = 64;
  localparam int unsigned MAX_PUT_DEF = 32;

  localparam logic [7:0] M_FF       = 8'hFF;
  localparam logic [7:0] M_RST0     = 8'hD0;
  localparam logic [7:0] M_RST1     = 8'hD1;
  localparam logic [7:0] M_RST2     = 8'hD2;
  localparam logic [7:0] M_RST3     = 8'hD3;
  localparam logic [7:0] M_RST4     = 8'hD4;
  localparam logic [7:0] M_RST5     = 8'hD5;
  localparam logic [7:0] M_RST6     = 8'hD6;
  localparam logic [7:0] M_RST7     = 8'hD7;
  localparam logic [7:0] M_EOI      = 8'hD9;
  localparam logic [7:0] STUFF_BYTE = 8'h00;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_PAD     = 3'd2;
  localparam logic [2:0] S_MK_FF   = 3'd3;
  localparam logic [2:0] S_MK_CODE = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

endpackage

// File: rtl/aq_cjpeg_bytestuff.sv
// Byte stuffing (0x00 after data 0xFF) and 4-lane little-endian word assembly
// with output backpressure and a partial-word drain.
module aq_cjpeg_bytestuff
  import aq_cjpeg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  input  logic        byteMarker,
  output logic        byteReady,
  input  logic        drain,
  output logic        stuffEmpty,
  output logic        stuffPending,
  output logic [31:0] DataOut,
  output logic        DataOutEnable,
  output logic [2:0]  DataOutBytes,
  input  logic        DataOutReady
);

  logic [23:0] laneBuf;
  logic [1:0]  laneCnt;
  logic [31:0] wordReg;
  logic [2:0]  wordBytes;
  logic        wordValid;
  logic        stuffPend;

  logic       wordFree;
  logic       srcValid;
  logic [7:0] srcByte;
  logic       canPlace;
  logic       place;
  logic       doDrain;

  // A pending stuff byte owns the next slot, so the upstream sees not-ready.
  always_comb begin
    wordFree  = !wordValid || DataOutReady;
    srcValid  = stuffPend || byteValid;
    srcByte   = stuffPend ? STUFF_BYTE : byteData;
    canPlace  = (laneCnt != 2'd3) || wordFree;
    place     = srcValid && canPlace;
    byteReady = !stuffPend && canPlace;
    doDrain   = drain && !srcValid && (laneCnt != 2'd0) && wordFree;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      laneBuf   <= '0;
      laneCnt   <= '0;
      wordReg   <= '0;
      wordBytes <= '0;
      wordValid <= 1'b0;
      stuffPend <= 1'b0;
    end else begin
      if (wordValid && DataOutReady) wordValid <= 1'b0;

      if (place) begin
        if (laneCnt == 2'd3) begin
          wordReg   <= {srcByte, laneBuf};
          wordBytes <= 3'd4;
          wordValid <= 1'b1;
          laneBuf   <= '0;
          laneCnt   <= '0;
        end else begin
          laneBuf[{laneCnt, 3'b000} +: 8] <= srcByte;
          laneCnt <= laneCnt + 2'd1;
        end
      end else if (doDrain) begin
        wordReg   <= {8'h00, laneBuf};
        wordBytes <= {1'b0, laneCnt};
        wordValid <= 1'b1;
        laneBuf   <= '0;
        laneCnt   <= '0;
      end

      if (stuffPend) begin
        if (place) stuffPend <= 1'b0;
      end else if (byteValid && byteReady && !byteMarker && byteData == M_FF) begin
        stuffPend <= 1'b1;
      end
    end
  end

  assign DataOut       = wordReg;
  assign DataOutEnable = wordValid;
  assign DataOutBytes  = wordBytes;
  assign stuffEmpty    = (laneCnt == 2'd0) && !wordValid && !stuffPend;
  assign stuffPending  = stuffPend;

endmodule

// File: rtl/aq_cjpeg_bitpack.sv
// JPEG entropy-coder bit packer: MSB-first accumulator, pad/marker/end FSM,
// feeding the stuffing word assembler.
module aq_cjpeg_bitpack
  import aq_cjpeg_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned MAX_PUT = MAX_PUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PutBits,
  input  logic [5:0]         PutWidth,
  input  logic [MAX_PUT-1:0] PutData,
  output logic               PutReady,
  input  logic               Flush,
  input  logic               MarkerReq,
  input  logic [7:0]         MarkerCode,
  input  logic               EndReq,
  output logic [31:0]        DataOut,
  output logic               DataOutEnable,
  output logic [2:0]         DataOutBytes,
  input  logic               DataOutReady,
  output logic               DataOutEnd,
  output logic               Busy
);

  localparam int unsigned CW = $clog2(ACC_W + MAX_PUT + 1);
  localparam logic [ACC_W-1:0] ONES = '1;

  logic [2:0]       state, stateNext;
  logic [ACC_W-1:0] acc, accNext;
  logic [CW-1:0]    bitCnt, bitCntNext;
  logic             mkPend, endPend, endFlag;
  logic [7:0]       mkCode;

  logic             widthOk, accept, pad, extract, anyReq;
  logic [2:0]       padN;
  logic [ACC_W-1:0] putMasked, padOnes;
  logic             byteValid, byteReady, byteMarker;
  logic [7:0]       byteData;
  logic             stuffEmpty, stuffPending, drain;

  always_comb begin
    widthOk   = (PutWidth != 6'd0) && (32'(PutWidth) <= MAX_PUT);
    PutReady  = ((state == S_RUN) || (state == S_IDLE) || (state == S_DONE)) &&
                (32'(bitCnt) <= ACC_W - MAX_PUT);
    accept    = PutBits && PutReady && widthOk;
    putMasked = {{(ACC_W-MAX_PUT){1'b0}}, PutData} & ~(ONES << PutWidth);
    padN      = 3'(4'd8 - {1'b0, bitCnt[2:0]});
    pad       = (state == S_PAD) && (padN != 3'd0);
    padOnes   = ~(ONES << padN);
    anyReq    = EndReq || MarkerReq || Flush;

    byteMarker = (state == S_MK_FF) || (state == S_MK_CODE);
    byteValid  = (bitCnt >= CW'(8)) || byteMarker;
    if (state == S_MK_FF)        byteData = M_FF;
    else if (state == S_MK_CODE) byteData = mkCode;
    else                         byteData = 8'(acc >> (bitCnt - CW'(8)));
    extract = (bitCnt >= CW'(8)) && byteReady;
    drain   = (state == S_DRAIN);
  end

  // Accept and pad are exclusive (PutReady is low in PAD); extraction reads the
  // old accumulator, so its byte index is unaffected by the same-cycle shift.
  always_comb begin
    accNext    = acc;
    bitCntNext = bitCnt;
    if (accept) begin
      accNext    = (acc << PutWidth) | putMasked;
      bitCntNext = bitCnt + CW'(PutWidth);
    end else if (pad) begin
      accNext    = (acc << padN) | padOnes;
      bitCntNext = bitCnt + CW'(padN);
    end
    if (extract) bitCntNext = bitCntNext - CW'(8);
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:    if (accept) stateNext = S_RUN;
      S_RUN:     if (anyReq) stateNext = S_PAD;
      S_PAD: begin
        // Wait for the stuff byte after a padded 0xFF before any marker.
        if (bitCnt == '0 && !stuffPending) begin
          if (mkPend)       stateNext = S_MK_FF;
          else if (endPend) stateNext = S_DRAIN;
          else              stateNext = S_RUN;
        end
      end
      S_MK_FF:   if (byteReady) stateNext = S_MK_CODE;
      S_MK_CODE: if (byteReady) stateNext = (mkCode == M_EOI) ? S_DRAIN : S_RUN;
      S_DRAIN:   if (stuffEmpty) stateNext = S_DONE;
      S_DONE:    if (accept) stateNext = S_RUN;
      default:   stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      bitCnt  <= '0;
      mkPend  <= 1'b0;
      endPend <= 1'b0;
      mkCode  <= '0;
      endFlag <= 1'b0;
    end else begin
      state  <= stateNext;
      acc    <= accNext;
      bitCnt <= bitCntNext;
      if (state == S_RUN && anyReq) begin
        endPend <= EndReq;
        mkPend  <= !EndReq && MarkerReq;
        if (!EndReq && MarkerReq) mkCode <= MarkerCode;
      end
      if (state == S_DRAIN && stateNext == S_DONE) endFlag <= 1'b1;
      else if (state == S_DONE && accept)          endFlag <= 1'b0;
    end
  end

  aq_cjpeg_bytestuff u_bytestuff (
    .clk          (clk),
    .rst          (rst),
    .byteValid    (byteValid),
    .byteData     (byteData),
    .byteMarker   (byteMarker),
    .byteReady    (byteReady),
    .drain        (drain),
    .stuffEmpty   (stuffEmpty),
    .stuffPending (stuffPending),
    .DataOut      (DataOut),
    .DataOutEnable(DataOutEnable),
    .DataOutBytes (DataOutBytes),
    .DataOutReady (DataOutReady)
  );

  assign DataOutEnd = endFlag;
  assign Busy       = (state != S_IDLE) || (bitCnt != '0) || !stuffEmpty;

endmodule
